// File: rtl/output_pkg.sv
// output_pkg: FSM states, mode codes, RGB pixel type and the grey/heat-map colour mapping
package output_pkg;
  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;
  localparam logic MODE_GRAY = 1'b0;
  localparam logic MODE_HEAT = 1'b1;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;
  function automatic rgb_t map_pixel(input logic mode, input logic [7:0] y);
    logic [7:0] s;
    s = {y[6:0], 1'b0};
    return mode != MODE_HEAT ? rgb_t'{r: y, g: y, b: y} :
           y[7] ? rgb_t'{r: s, g: 8'hff - s, b: 8'h00} :
                  rgb_t'{r: 8'h00, g: s, b: 8'hff - s};
  endfunction
endpackage

// File: rtl/pixel_fifo2.sv
// pixel_fifo2: 2-entry registered buffer; in_data/in_valid/in_ready upstream, out_data/out_valid/out_ready downstream
module pixel_fifo2 #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);
  logic [WIDTH-1:0] tail;
  logic [1:0] count;
  logic push, pop;
  assign in_ready = count != 2'd2;
  assign out_valid = count != 2'd0;
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_data <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (push && (count == 2'd0 || (count == 2'd1 && pop))) out_data <= in_data;
      else if (pop && count == 2'd2) out_data <= tail;
      if (push && (count == 2'd2 || (count == 2'd1 && !pop))) tail <= in_data;
      count <= count + 2'(push) - 2'(pop);
    end
endmodule

// File: rtl/gray2rgb_output.sv
// gray2rgb_output: framed gray->RGB formatter; gray_i/valid_i/ready_o/done_i/mode_i in, red/green/blue_o/valid_o/ready_i/sof/eol/eof_o out, done_o/short_frame_o pulses
module gray2rgb_output
  import output_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] gray_i,
  input  logic       valid_i,
  output logic       ready_o,
  input  logic       done_i,
  input  logic       mode_i,
  output logic [7:0] red_o,
  output logic [7:0] green_o,
  output logic [7:0] blue_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       sof_o,
  output logic       eol_o,
  output logic       eof_o,
  output logic       done_o,
  output logic       short_frame_o
);
  localparam int CW = IMG_WIDTH > 1 ? $clog2(IMG_WIDTH) : 1;
  localparam int RW = IMG_HEIGHT > 1 ? $clog2(IMG_HEIGHT) : 1;
  localparam int PIX = IMG_WIDTH * IMG_HEIGHT;
  localparam int NW = $clog2(PIX + 1);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT - 1);
  localparam logic [NW-1:0] PIX_N = NW'(PIX);
  state_t state, state_n;
  logic mode_q, short_n, short_q, fifo_ready, push, pop, eol, eof;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [NW-1:0] in_cnt, in_next;
  rgb_t pix_in, pix_out;
  assign ready_o = fifo_ready && (state == IDLE || state == STREAM);
  assign push = valid_i && ready_o;
  assign pop = valid_o && ready_i;
  // the first pixel of a frame is mapped with the mode being latched alongside it
  assign pix_in = map_pixel(state == IDLE ? mode_i : mode_q, gray_i);
  assign in_next = in_cnt + NW'(push);
  assign eol = col == COL_MAX;
  assign eof = eol && row == ROW_MAX;
  assign {red_o, green_o, blue_o} = pix_out;
  assign sof_o = valid_o && col == '0 && row == '0;
  assign eol_o = valid_o && eol;
  assign eof_o = valid_o && eof;
  assign done_o = state == DONE;
  assign short_frame_o = short_q;
  pixel_fifo2 #(.WIDTH($bits(rgb_t))) u_fifo (
    .clk,
    .rst,
    .in_data(pix_in),
    .in_valid(push),
    .in_ready(fifo_ready),
    .out_data(pix_out),
    .out_valid(valid_o),
    .out_ready(ready_i)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    short_n = 1'b0;
    if (state == IDLE && push) state_n = STREAM;
    else if (state == STREAM && pop && eof) state_n = DONE;
    else if (state == STREAM && done_i && in_next < PIX_N) begin
      state_n = FLUSH;
      short_n = 1'b1;
    end
    else if (state == FLUSH && !valid_o) state_n = DONE;
    else if (state == DONE) state_n = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      col <= '0;
      row <= '0;
      in_cnt <= '0;
      mode_q <= MODE_GRAY;
      short_q <= 1'b0;
    end else begin
      short_q <= short_n;
      if (state == IDLE && push) mode_q <= mode_i;
      if (state_n == DONE) begin
        col <= '0;
        row <= '0;
        in_cnt <= '0;
      end else begin
        if (pop) col <= eol ? '0 : col + 1'b1;
        if (pop && eol) row <= eof ? '0 : row + 1'b1;
        if (push && in_cnt != PIX_N) in_cnt <= in_next;
      end
    end
endmodule

// File: tb/tb_gray2rgb_output.sv
// tb_gray2rgb_output: directed table and sequence checks of gray2rgb_output on a 4x2 frame
module tb_gray2rgb_output;
  localparam int W = 4;
  localparam int H = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] gray_i, red_o, green_o, blue_o;
  logic valid_i, ready_o, done_i, mode_i, valid_o, ready_i;
  logic sof_o, eol_o, eof_o, done_o, short_frame_o;
  int pass_n = 0, total_n = 0;
  typedef struct {
    logic mode;
    logic [7:0] gray;
    logic [7:0] r, g, b;
    logic sof, eol, eof;
  } vec_t;
  vec_t tbl[16];
  always #5 clk = ~clk;
  gray2rgb_output #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk, .rst, .gray_i, .valid_i, .ready_o, .done_i, .mode_i,
    .red_o, .green_o, .blue_o, .valid_o, .ready_i,
    .sof_o, .eol_o, .eof_o, .done_o, .short_frame_o
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic run_frame(input int n, input logic [7:0] base, input int stall_lo,
                           input int stall_hi, input int done_mode);
    int sent = 0, got = 0, dn = 0, sh = 0, post = 0;
    logic idone = 1'b0;
    logic [7:0] g;
    for (int c = 0; c < 60 && post < 2; c++) begin
      valid_i = sent < n;
      gray_i = base + 8'(sent);
      mode_i = 1'b0;
      ready_i = !(c >= stall_lo && c < stall_hi);
      done_i = 1'b0;
      if (done_mode == 1 && sent == n - 1 && ready_o) done_i = 1'b1;
      if (done_mode == 2 && sent == n && !idone) begin
        done_i = 1'b1;
        idone = 1'b1;
      end
      if (c == stall_lo + 1 && stall_hi > stall_lo + 1) chk("stall_ready", ready_o, 0);
      if (valid_o) begin
        g = base + 8'(got);
        chk("pix", {red_o, green_o, blue_o, sof_o, eol_o, eof_o},
            {g, g, g, got == 0, (got % W) == W - 1, got == W * H - 1});
      end
      if (valid_o && ready_i) got++;
      if (valid_i && ready_o) sent++;
      step;
      if (done_o) dn++;
      if (short_frame_o) sh++;
      if (dn > 0) post++;
    end
    valid_i = 1'b0;
    done_i = 1'b0;
    ready_i = 1'b1;
    chk("sent", sent, n);
    chk("got", got, n);
    chk("done_cnt", dn, 1);
    chk("short_cnt", sh, n < W * H ? 1 : 0);
    chk("ready_after", ready_o, 1);
  endtask
  initial begin
    valid_i = 1'b0;
    gray_i = '0;
    done_i = 1'b0;
    mode_i = 1'b0;
    ready_i = 1'b1;
    for (int k = 0; k < 8; k++)
      tbl[k] = '{1'b0, 8'(k), 8'(k), 8'(k), 8'(k), k == 0, k % 4 == 3, k == 7};
    tbl[8]  = '{1'b1, 8'd0,   8'd0,   8'd0,   8'd255, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 8'd127, 8'd0,   8'd254, 8'd1,   1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 8'd128, 8'd0,   8'd255, 8'd0,   1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 8'd255, 8'd254, 8'd1,   8'd0,   1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 8'd64,  8'd0,   8'd128, 8'd127, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 8'd200, 8'd144, 8'd111, 8'd0,   1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 8'd1,   8'd0,   8'd2,   8'd253, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 8'd129, 8'd2,   8'd253, 8'd0,   1'b0, 1'b1, 1'b1};
    #1;
    chk("rst_valid", valid_o, 0);
    chk("rst_ready", ready_o, 1);
    chk("rst_rgb", {red_o, green_o, blue_o}, 0);
    chk("rst_flags", {sof_o, eol_o, eof_o, done_o, short_frame_o}, 0);
    @(negedge clk);
    rst = 1'b0;
    step;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 8; i++) begin
        vec_t v;
        v = tbl[8 * f + i];
        valid_i = 1'b1;
        gray_i = v.gray;
        mode_i = i == 0 ? v.mode : !v.mode;
        step;
        chk("tbl_pix", {valid_o, ready_o, red_o, green_o, blue_o, sof_o, eol_o, eof_o},
            {1'b1, 1'b1, v.r, v.g, v.b, v.sof, v.eol, v.eof});
      end
      valid_i = 1'b0;
      step;
      chk("tbl_done", {done_o, ready_o, valid_o}, 3'b100);
      step;
      chk("tbl_idle", {done_o, ready_o}, 2'b01);
    end
    done_i = 1'b1;
    step;
    done_i = 1'b0;
    chk("idle_done_i", {done_o, short_frame_o, ready_o}, 3'b001);
    step;
    chk("idle_done_i2", {done_o, short_frame_o, ready_o}, 3'b001);
    run_frame(8, 8'd20, 2, 7, 1);
    run_frame(5, 8'd100, 4, 9, 2);
    run_frame(8, 8'd30, 0, 0, 0);
    valid_i = 1'b1;
    ready_i = 1'b0;
    gray_i = 8'd50;
    step;
    gray_i = 8'd51;
    step;
    chk("pre_rst", {valid_o, ready_o, red_o}, {1'b1, 1'b0, 8'd50});
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out", {valid_o, ready_o, done_o, short_frame_o}, 4'b0100);
    chk("mid_rst_rgb", {red_o, green_o, blue_o, sof_o, eol_o, eof_o}, 0);
    @(negedge clk);
    rst = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    step;
    chk("post_rst", {valid_o, ready_o}, 2'b01);
    run_frame(8, 8'd60, 3, 5, 0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
